// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch controller.
// Holds the RV32I branch funct3 codes, the control-transfer kind encoding
// and the controller state encoding.
package branch_pkg;

    // Branch conditions, RV32I funct3 encoding
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Control-transfer kind
    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_BR   = 2'b01;
    localparam logic [1:0] KIND_JAL  = 2'b10;
    localparam logic [1:0] KIND_JALR = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StEval  = 2'b01,
        StFlush = 2'b10
    } state_e;

endpackage

// File: rtl/branch_comp.sv
// Branch condition comparator.
// Ports:
//   op1, op2 : rs1 / rs2 operand values
//   funct3   : RV32I branch condition
//   branch   : 1 when the condition holds; 0 for unsupported funct3 (010/011)
module branch_comp
    import branch_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  funct3,
    output logic        branch
);

    always_comb begin
        branch = 1'b0;
        case (funct3)
            F3_BEQ:  branch = (op1 == op2);
            F3_BNE:  branch = (op1 != op2);
            F3_BLT:  branch = ($signed(op1) <  $signed(op2));
            F3_BGE:  branch = ($signed(op1) >= $signed(op2));
            F3_BLTU: branch = (op1 <  op2);
            F3_BGEU: branch = (op1 >= op2);
            default: branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch sequencing controller.
// Accepts one control-transfer instruction per handshake, resolves it one
// cycle later (direction, target, link address), issues a one-cycle PC
// redirect plus a FLUSH_CYCLES-long flush on taken aligned transfers, and
// keeps saturating resolved/taken counters.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : request handshake
//   in_kind .. in_op2    : decoded instruction fields and operands
//   kill                 : abort the instruction in EVAL
//   redirect_valid/_pc   : fetch redirect pulse and target
//   flush                : squash younger stages
//   result_valid/_taken  : resolution pulse and direction
//   link_addr            : pc+4, valid with result_valid
//   misalign_exc         : taken target not word aligned
//   total_cnt, taken_cnt : statistics
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic             kill,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             result_valid,
    output logic             result_taken,
    output logic [31:0]      link_addr,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    // Down-counter holds remaining flush cycles minus one
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [31:0]       pc_q, imm_q, op1_q, op2_q;
    logic [2:0]        f3_q;
    logic [1:0]        kind_q;
    logic [CNT_W-1:0]  total_q, taken_q;

    logic        cmp_branch;
    logic        taken;
    logic [31:0] target;
    logic [31:0] jalr_sum;
    logic [31:0] link;

    branch_comp u_comp (
        .op1    (op1_q),
        .op2    (op2_q),
        .funct3 (f3_q),
        .branch (cmp_branch)
    );

    assign jalr_sum = op1_q + imm_q;
    assign target   = (kind_q == KIND_JALR) ? {jalr_sum[31:1], 1'b0} : (pc_q + imm_q);
    assign link     = pc_q + 32'd4;
    assign taken    = ((kind_q == KIND_BR) && cmp_branch) ||
                      (kind_q == KIND_JAL) || (kind_q == KIND_JALR);

    always_comb begin
        state_d        = state_q;
        fcnt_d         = fcnt_q;
        in_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        flush          = 1'b0;
        result_valid   = 1'b0;
        result_taken   = 1'b0;
        link_addr      = 32'd0;
        misalign_exc   = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                state_d = StIdle;
                if (!kill) begin
                    result_valid = 1'b1;
                    result_taken = taken;
                    link_addr    = link;
                    if (taken) begin
                        if (target[1:0] != 2'b00) begin
                            misalign_exc = 1'b1;
                        end else begin
                            redirect_valid = 1'b1;
                            redirect_pc    = target;
                            if (FLUSH_CYCLES > 0) begin
                                state_d = StFlush;
                                fcnt_d  = FCNT_LOAD;
                            end
                        end
                    end
                end
            end
            StFlush: begin
                flush = 1'b1;
                if (fcnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            fcnt_q  <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            f3_q    <= '0;
            kind_q  <= KIND_NONE;
            total_q <= '0;
            taken_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (in_valid && in_ready) begin
                pc_q   <= in_pc;
                imm_q  <= in_imm;
                op1_q  <= in_op1;
                op2_q  <= in_op2;
                f3_q   <= in_funct3;
                kind_q <= in_kind;
            end
            if (result_valid && (total_q != '1)) begin
                total_q <= total_q + CNT_W'(1);
            end
            if (result_valid && result_taken && (taken_q != '1)) begin
                taken_q <= taken_q + CNT_W'(1);
            end
        end
    end

    assign total_cnt = total_q;
    assign taken_cnt = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: main instance (defaults) plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [31:0] in_pc, in_imm, in_op1, in_op2;
    logic        kill;

    logic        in_ready, redirect_valid, flush, result_valid, result_taken, misalign_exc;
    logic [31:0] redirect_pc, link_addr;
    logic [15:0] total_cnt, taken_cnt;

    logic        s_in_ready, s_redirect_valid, s_flush, s_result_valid, s_result_taken;
    logic        s_misalign_exc;
    logic [31:0] s_redirect_pc, s_link_addr;
    logic [1:0]  s_total_cnt, s_taken_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
        .in_op1(in_op1), .in_op2(in_op2), .kill(kill),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .result_valid(result_valid), .result_taken(result_taken), .link_addr(link_addr),
        .misalign_exc(misalign_exc), .total_cnt(total_cnt), .taken_cnt(taken_cnt)
    );

    branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
        .in_op1(in_op1), .in_op2(in_op2), .kill(kill),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush(s_flush),
        .result_valid(s_result_valid), .result_taken(s_result_taken),
        .link_addr(s_link_addr), .misalign_exc(s_misalign_exc),
        .total_cnt(s_total_cnt), .taken_cnt(s_taken_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; return at the following negedge (EVAL).
    task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] op1,
                         input logic [31:0] op2);
        @(negedge clk);
        in_kind   = kind;
        in_funct3 = f3;
        in_pc     = pc;
        in_imm    = imm;
        in_op1    = op1;
        in_op2    = op2;
        in_valid  = 1'b1;
        check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // EVAL-cycle outputs: {result_valid, result_taken, redirect_valid, misalign_exc}
    task automatic check_eval(input string tag, input logic [3:0] flags,
                              input logic [31:0] rpc, input logic [31:0] link);
        check_eq({tag, "_flags"},
                 {28'd0, result_valid, result_taken, redirect_valid, misalign_exc},
                 {28'd0, flags});
        check_eq({tag, "_rpc"}, redirect_pc, rpc);
        check_eq({tag, "_link"}, link_addr, link);
        check_eq({tag, "_eval_rdy"}, {31'd0, in_ready}, 32'd0);
    endtask

    // Two flush cycles then idle again.
    task automatic check_flush2(input string tag);
        @(negedge clk);
        check_eq({tag, "_fl1"}, {30'd0, flush, in_ready}, 32'b10);
        @(negedge clk);
        check_eq({tag, "_fl2"}, {30'd0, flush, in_ready}, 32'b10);
        @(negedge clk);
        check_eq({tag, "_fl_end"}, {30'd0, flush, in_ready}, 32'b01);
    endtask

    task automatic check_noflush(input string tag);
        @(negedge clk);
        check_eq({tag, "_idle"}, {30'd0, flush, in_ready}, 32'b01);
    endtask

    task automatic check_cnt(input string tag, input int tot, input int tak);
        check_eq({tag, "_total"}, {16'd0, total_cnt}, tot);
        check_eq({tag, "_taken"}, {16'd0, taken_cnt}, tak);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0;
        in_kind = 2'b00; in_funct3 = 3'b000;
        in_pc = '0; in_imm = '0; in_op1 = '0; in_op2 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_pulses", {27'd0, flush, result_valid, result_taken, redirect_valid,
                 misalign_exc}, 32'd0);
        check_eq("rst_rpc", redirect_pc, 32'd0);
        check_eq("rst_link", link_addr, 32'd0);
        check_cnt("rst", 0, 0);
        rst_n = 1'b1;
        #1 check_eq("rst_rel_ready", {31'd0, in_ready}, 32'd1);

        // BEQ taken
        issue(2'b01, 3'b000, 32'h100, 32'h20, 32'hA5A5A5A5, 32'hA5A5A5A5);
        check_eval("beq", 4'b1110, 32'h120, 32'h104);
        check_flush2("beq");
        check_cnt("beq", 1, 1);

        // BLT 2 < -5 is false
        issue(2'b01, 3'b100, 32'h200, 32'h40, 32'd2, 32'hFFFFFFFB);
        check_eval("blt", 4'b1000, 32'h0, 32'h204);
        check_noflush("blt");
        check_cnt("blt", 2, 1);

        // BGE 2 >= -5 taken
        issue(2'b01, 3'b101, 32'h300, 32'hFFFFFFF0, 32'd2, 32'hFFFFFFFB);
        check_eval("bge", 4'b1110, 32'h2F0, 32'h304);
        check_flush2("bge");
        check_cnt("bge", 3, 2);

        // BGEU 2 >= 0xFFFFFFFB false
        issue(2'b01, 3'b111, 32'h400, 32'h8, 32'd2, 32'hFFFFFFFB);
        check_eval("bgeu", 4'b1000, 32'h0, 32'h404);
        check_noflush("bgeu");

        // Unsupported funct3 with equal operands, and kind NONE: both not taken
        issue(2'b01, 3'b010, 32'h500, 32'h8, 32'd7, 32'd7);
        check_eval("f3bad", 4'b1000, 32'h0, 32'h504);
        check_noflush("f3bad");
        issue(2'b00, 3'b000, 32'h600, 32'h8, 32'd7, 32'd7);
        check_eval("none", 4'b1000, 32'h0, 32'h604);
        check_noflush("none");
        check_cnt("nt", 6, 2);

        // JALR: (0x1001 + 4) & ~1 = 0x1004
        issue(2'b11, 3'b000, 32'h40, 32'h4, 32'h1001, 32'h0);
        check_eval("jalr", 4'b1110, 32'h1004, 32'h44);
        check_flush2("jalr");
        check_cnt("jalr", 7, 3);

        // Misaligned JAL: 0x100 + 6
        issue(2'b10, 3'b000, 32'h100, 32'h6, 32'h0, 32'h0);
        check_eval("mis", 4'b1101, 32'h0, 32'h104);
        check_noflush("mis");
        check_cnt("mis", 8, 4);

        // Kill in EVAL on a taken BNE
        issue(2'b01, 3'b001, 32'h700, 32'h10, 32'd1, 32'd2);
        kill = 1'b1;
        #1 check_eval("kill", 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        kill = 1'b0;
        check_eq("kill_idle", {30'd0, flush, in_ready}, 32'b01);
        check_cnt("kill", 8, 4);

        // Wrap-around JAL
        issue(2'b10, 3'b000, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0);
        check_eval("wrap", 4'b1110, 32'h4, 32'h0);
        check_flush2("wrap");
        check_cnt("wrap", 9, 5);

        // Reset on the first flush cycle
        issue(2'b01, 3'b000, 32'h100, 32'h20, 32'd3, 32'd3);
        @(negedge clk);
        check_eq("mid_fl1", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        #1 check_eq("mid_rdy_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_eq("mid_flush", {31'd0, flush}, 32'd0);
        check_eq("mid_rdy", {31'd0, in_ready}, 32'd0);
        check_cnt("mid", 0, 0);
        @(negedge clk);
        check_eq("mid_rdy2", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1 check_eq("mid_rel", {31'd0, in_ready}, 32'd1);

        // Five taken JALs: CNT_W=2 instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            issue(2'b10, 3'b000, 32'h1000, 32'h10, 32'h0, 32'h0);
            check_flush2("sat");
        end
        check_eq("sat_taken", {30'd0, s_taken_cnt}, 32'd3);
        check_eq("sat_total", {30'd0, s_total_cnt}, 32'd3);
        check_cnt("sat_wide", 5, 5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequencing controller for the execute-stage branch datapath.
- Accepts one decoded control-transfer instruction (BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR) per transaction over a valid/ready handshake.
- Registers the operands and drives the existing `branch_comp` comparator. Computes target and link addresses.
- Issues a one-cycle PC redirect and a multi-cycle pipeline flush on taken transfers. Keeps taken/total statistics counters.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` is held high after a redirect (0 = no flush phase).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_kind  in  2  00 none, 01 conditional branch, 10 JAL, 11 JALR
- in_funct3  in  3  branch condition, RV32I encoding
- in_pc  in  32  instruction PC
- in_imm  in  32  sign-extended immediate
- in_op1  in  32  rs1 value
- in_op2  in  32  rs2 value
- kill  in  1  abort the held instruction (older exception)
- redirect_valid  out  1  one-cycle pulse: fetch must jump
- redirect_pc  out  32  jump target, valid with redirect_valid
- flush  out  1  squash younger pipeline stages
- result_valid  out  1  one-cycle pulse per resolved instruction
- result_taken  out  1  resolved direction
- link_addr  out  32  pc+4 for rd writeback, valid with result_valid
- misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned
- total_cnt  out  CNT_W  resolved instructions
- taken_cnt  out  CNT_W  taken instructions

Behaviour:
- States: IDLE, EVAL, FLUSH.
- Reset (rst_n low at a clock edge):
  - state returns to IDLE from any state, including mid-FLUSH.
  - Counters clear to 0. All pulse outputs, flush, redirect_pc and link_addr reset to 0.
  - in_ready is forced 0 while rst_n is low.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch pc, imm, op1, op2, funct3 and kind, then go to EVAL.
- EVAL (one cycle after accept):
  - in_ready=0. Latched op1/op2/funct3 feed `branch_comp`.
  - taken = (kind==01 & branch) | kind==10 | kind==11. kind==00 resolves not-taken.
  - target = pc+imm for kind 01/10. For JALR, target = (op1+imm) with bit0 cleared. All arithmetic is modulo 2^32 (wrap-around is legal).
  - link_addr = pc+4.
  - Unless killed, result_valid pulses with result_taken and link_addr. This is a combinational decode of the EVAL state, so total latency is accept-to-result 1 cycle.
  - Taken with target[1:0]!=0: misalign_exc pulses, no redirect, next state IDLE.
  - Taken and aligned: redirect_valid=1 and redirect_pc=target in the same cycle. Next state is FLUSH if FLUSH_CYCLES>0, else IDLE.
  - Not taken: next state IDLE.
  - kill=1 in EVAL suppresses every pulse and counter update, and the next state is IDLE.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles, tracked by a down-counter loaded on entry. Then IDLE.
  - in_ready=0 throughout. kill is ignored.
- Counters:
  - total_cnt increments on each non-killed resolution.
  - taken_cnt increments on taken resolutions, including misaligned ones.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Throughput: at most one request per 2 cycles (not taken) or 2+FLUSH_CYCLES cycles (taken).
- An unsupported funct3 (010/011) relies on `branch_comp` returning 0, so the instruction resolves not-taken.

Decomposition:
- Shared package `branch_pkg`:
  - funct3 constants F3_BEQ..F3_BGEU.
  - Kind encodings KIND_NONE/BR/JAL/JALR.
  - State encoding for IDLE/EVAL/FLUSH.
- Sub-module: existing `branch_comp` instantiated unchanged. Target/link adders stay inline.

Test Plan:
- BEQ accept: op1=op2=32'hA5A5A5A5, pc=32'h100, imm=32'h20, FLUSH_CYCLES=2 -> result_valid, result_taken=1 and redirect_pc=32'h120 one cycle after accept; flush high exactly 2 cycles; in_ready returns 1 the cycle after; total_cnt=1, taken_cnt=1.
- BLT not taken: op1=2, op2=-5, funct3=100 -> result_taken=0, no redirect, no flush, in_ready high 2 cycles after accept.
- JALR: op1=32'h1001, imm=32'h4, pc=32'h40 -> redirect_pc=32'h1004, link_addr=32'h44. Misaligned JAL with pc=32'h100, imm=32'h6 -> misalign_exc pulse, no redirect_valid, taken_cnt increments.
- Kill: accept BNE taken, assert kill in EVAL -> no result_valid, redirect or flush; counters unchanged; next state IDLE.
- Reset mid-flush: assert rst_n=0 on the 1st flush cycle -> next edge flush=0, counters 0, in_ready=0 until rst_n=1, then in_ready=1.
- Saturation and wrap: CNT_W=2, resolve 5 taken branches -> taken_cnt=3. pc=32'hFFFFFFFC with JAL imm=8 -> redirect_pc=32'h4, link_addr=0.
